// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display blocks: digit count,
// blank pattern, hex-to-segment table and the frame record.
package seg_pkg;

    localparam int SEG_DIGITS = 6;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low g..a patterns, entry n at [n]; listed from F down to 0.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic [23:0] hex;
        logic [5:0]  dp;
        logic [5:0]  blank;
    } seg_frame_t;

    function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment (g..a) pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = hex_seg(nibble);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed seven-segment scan controller with a double-buffered
// frame input that commits only at frame boundaries.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_CNT = 50000,
    parameter int DEAD_CNT = 500,
    parameter int CNT_W    = 22
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        frm_valid,
    output logic        frm_ready,
    input  logic [23:0] frm_hex,
    input  logic [5:0]  frm_dp,
    input  logic [5:0]  frm_blank,
    output logic [5:0]  sel,
    output logic [7:0]  seg,
    output logic        frm_commit
);

    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       idx_reg;
    logic             pend_full_reg;
    seg_frame_t       pend_reg;
    seg_frame_t       disp_reg;
    logic [5:0]       sel_reg;
    logic [7:0]       seg_reg;
    logic             commit_reg;

    logic [5:0] sel_next;
    logic [7:0] seg_next;
    logic       last_cnt;
    logic       tick;
    logic       boundary;
    logic       xfer;
    logic       commit;
    logic       in_dead;
    logic [6:0] dec_pattern;
    logic [3:0] nib [SEG_DIGITS];

    assign last_cnt = (cnt_reg == CNT_W'(SCAN_CNT - 1));
    assign tick     = en && last_cnt;
    assign boundary = tick && (idx_reg == 3'(SEG_DIGITS - 1));
    assign xfer     = frm_valid && !pend_full_reg;
    assign commit   = boundary && pend_full_reg;

    generate
        if (DEAD_CNT == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (cnt_reg < CNT_W'(DEAD_CNT));
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < SEG_DIGITS; gi++) begin : g_nib
            assign nib[gi] = disp_reg.hex[4*gi +: 4];
        end
    endgenerate

    seg_hex_decode u_dec (
        .nibble  (nib[idx_reg]),
        .pattern (dec_pattern)
    );

    // Slot counter and digit index; disabling scan parks both at slot start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else if (!en) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else if (last_cnt) begin
            cnt_reg <= '0;
            idx_reg <= (idx_reg == 3'(SEG_DIGITS - 1)) ? 3'd0 : idx_reg + 3'd1;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Commit and transfer are exclusive: a full pending buffer blocks transfers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_full_reg  <= 1'b0;
            pend_reg       <= '0;
            disp_reg.hex   <= '0;
            disp_reg.dp    <= '0;
            disp_reg.blank <= '1;
        end else if (commit) begin
            disp_reg      <= pend_reg;
            pend_full_reg <= 1'b0;
        end else if (xfer) begin
            pend_reg.hex   <= frm_hex;
            pend_reg.dp    <= frm_dp;
            pend_reg.blank <= frm_blank;
            pend_full_reg  <= 1'b1;
        end
    end

    always_comb begin
        sel_next = '0;
        seg_next = SEG_OFF;
        if (en && !in_dead) begin
            sel_next = 6'b000001 << idx_reg;
            if (!disp_reg.blank[idx_reg]) begin
                seg_next = {~disp_reg.dp[idx_reg], dec_pattern};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_reg    <= '0;
            seg_reg    <= SEG_OFF;
            commit_reg <= 1'b0;
        end else begin
            sel_reg    <= sel_next;
            seg_reg    <= seg_next;
            commit_reg <= commit;
        end
    end

    assign sel        = sel_reg;
    assign seg        = seg_reg;
    assign frm_commit = commit_reg;
    assign frm_ready  = !pend_full_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_CNT=8, DEAD_CNT=2; edges are
// numbered from reset release so each expected value maps to a known slot.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        frm_valid = 1'b0;
    logic        frm_ready;
    logic [23:0] frm_hex = '0;
    logic [5:0]  frm_dp = '0;
    logic [5:0]  frm_blank = '0;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic        frm_commit;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    seg_scan_ctrl #(.SCAN_CNT(8), .DEAD_CNT(2), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .frm_valid  (frm_valid),
        .frm_ready  (frm_ready),
        .frm_hex    (frm_hex),
        .frm_dp     (frm_dp),
        .frm_blank  (frm_blank),
        .sel        (sel),
        .seg        (seg),
        .frm_commit (frm_commit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
        $display("vec %0d %s cyc=%0d observed=%h expected=%h", n_vec, tag, cyc, obs, exp);
    endtask

    // Advance to just after edge k (counted from reset release).
    task automatic go_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic out_chk(input string tag, input logic [5:0] esel, input logic [7:0] eseg);
        chk({tag, ".sel"}, {18'd0, sel}, {18'd0, esel});
        chk({tag, ".seg"}, {16'd0, seg}, {16'd0, eseg});
    endtask

    initial begin
        #22 rst = 1'b1;
        #1;
        chk("reset.sel", {18'd0, sel}, 24'd0);
        chk("reset.seg", {16'd0, seg}, 24'hFF);
        chk("reset.ready", {23'd0, frm_ready}, 24'd1);
        chk("reset.commit", {23'd0, frm_commit}, 24'd0);

        // Blank display scanning; frame A pushed so it transfers at edge 5.
        go_to(1);  out_chk("e1.dead", 6'h00, 8'hFF);
        go_to(3);  out_chk("e3.dig0", 6'h01, 8'hFF);
        go_to(4);
        frm_valid = 1'b1; frm_hex = 24'hFEDCBA; frm_dp = 6'h00; frm_blank = 6'h00;
        go_to(5);
        chk("e5.ready", {23'd0, frm_ready}, 24'd0);
        frm_valid = 1'b0;
        go_to(8);  out_chk("e8.dig0end", 6'h01, 8'hFF);
        go_to(9);  out_chk("e9.dead", 6'h00, 8'hFF);
        go_to(11); out_chk("e11.dig1", 6'h02, 8'hFF);
        go_to(43); out_chk("e43.dig5", 6'h20, 8'hFF);
        go_to(47); chk("e47.commit", {23'd0, frm_commit}, 24'd0);
        go_to(48);
        chk("e48.commit", {23'd0, frm_commit}, 24'd1);
        chk("e48.ready", {23'd0, frm_ready}, 24'd1);
        go_to(49);
        chk("e49.commit", {23'd0, frm_commit}, 24'd0);

        // Frame 012345 with dp on digit 2, then frame B held while pending is full.
        frm_valid = 1'b1; frm_hex = 24'h012345; frm_dp = 6'b000100; frm_blank = 6'h00;
        go_to(50);
        chk("e50.ready", {23'd0, frm_ready}, 24'd0);
        frm_hex = 24'hC0FFEE; frm_dp = 6'b000001; frm_blank = 6'b101010;
        go_to(51); out_chk("e51.A.dig0", 6'h01, 8'h88);
        chk("e51.ready", {23'd0, frm_ready}, 24'd0);
        go_to(91); out_chk("e91.A.dig5", 6'h20, 8'h8E);
        while (!frm_ready && cyc < 150) go_to(cyc + 1);
        chk("ready_rise_cycle", 24'(cyc), 24'd96);
        chk("e96.commit", {23'd0, frm_commit}, 24'd1);
        go_to(97);
        chk("e97.ready", {23'd0, frm_ready}, 24'd0);
        chk("e97.commit", {23'd0, frm_commit}, 24'd0);
        frm_valid = 1'b0;
        go_to(99);  out_chk("e99.F2.dig0", 6'h01, 8'h92);
        go_to(115); out_chk("e115.F2.dig2", 6'h04, 8'h30);
        go_to(144); chk("e144.commit", {23'd0, frm_commit}, 24'd1);
        go_to(147); out_chk("e147.B.dig0", 6'h01, 8'h06);
        go_to(155); out_chk("e155.B.dig1", 6'h02, 8'hFF);
        go_to(163); out_chk("e163.B.dig2", 6'h04, 8'h8E);
        go_to(172); out_chk("e172.B.dig3", 6'h08, 8'hFF);

        // Scan disable mid-slot on digit 3, restart from digit 0 with dead time.
        en = 1'b0;
        go_to(173); out_chk("e173.en_off", 6'h00, 8'hFF);
        go_to(175);
        en = 1'b1;
        go_to(176); out_chk("e176.restart_dead0", 6'h00, 8'hFF);
        go_to(177); out_chk("e177.restart_dead1", 6'h00, 8'hFF);
        go_to(178); out_chk("e178.restart_dig0", 6'h01, 8'h06);
        go_to(210); out_chk("e210.B.dig4", 6'h10, 8'hC0);

        // Fill pending, then reset asynchronously mid-frame.
        frm_valid = 1'b1; frm_hex = 24'h888888; frm_dp = 6'h3F; frm_blank = 6'h00;
        go_to(211);
        chk("e211.ready", {23'd0, frm_ready}, 24'd0);
        frm_valid = 1'b0;
        go_to(212);
        #3 rst = 1'b0;
        #1;
        chk("async_rst.sel", {18'd0, sel}, 24'd0);
        chk("async_rst.seg", {16'd0, seg}, 24'hFF);
        chk("async_rst.ready", {23'd0, frm_ready}, 24'd1);
        #12 rst = 1'b1;
        cyc = 0;
        go_to(3);  out_chk("post_rst.e3", 6'h01, 8'hFF);
        go_to(48); chk("post_rst.e48.commit", {23'd0, frm_commit}, 24'd0);
        go_to(51); out_chk("post_rst.e51", 6'h01, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 6-digit common-anode seven-segment display.
- Accepts a full 6-digit frame over a valid/ready handshake: hex nibbles, per-digit decimal points and per-digit blanking.
- Double-buffers the frame and commits it only at frame boundaries, so no digit ever shows a mix of old and new data.
- Drives one-hot digit select with a programmable dead time for ghost suppression, and sits between the display-data producer and the board pins.

Parameters:
- SCAN_CNT, 50000: clk cycles each digit is active (1 ms at 50 MHz); must be greater than DEAD_CNT.
- DEAD_CNT, 500: cycles at the start of each digit slot during which sel is all-zero; 0 disables dead time.
- CNT_W, 22: width of the slot counter; must satisfy 2^CNT_W >= SCAN_CNT.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  scan enable; 0 = display dark, counters held at 0
- frm_valid  in  1  producer offers a frame
- frm_ready  out  1  controller can accept a frame
- frm_hex  in  24  digit k nibble = frm_hex[4k+3:4k], digit 0 = bits [3:0]
- frm_dp  in  6  decimal point per digit, 1 = lit
- frm_blank  in  6  1 = digit dark
- sel  out  6  one-hot digit enable, active-high
- seg  out  8  segments active-low, bit7 = dp, bits[6:0] = g..a
- frm_commit  out  1  one-cycle pulse when pending frame moves to the display buffer

Behaviour:
- Reset values:
  - sel = 0, seg = 8'hFF, frm_ready = 1, frm_commit = 0.
  - Slot counter = 0, digit index = 0, pending buffer empty.
  - Display buffer: hex = 0, dp = 0, blank = 6'b111111, so the display is dark until the first commit.
- Slot counter counts 0..SCAN_CNT-1 and wraps. Tick = counter at SCAN_CNT-1 and en = 1.
  - On a tick the digit index advances 0→1→…→5→0.
  - A tick with index = 5 is a frame boundary.
- Handshake:
  - Transfer occurs when frm_valid && frm_ready are high on the same clk edge; frm_hex, frm_dp and frm_blank are captured into the pending buffer.
  - frm_ready is registered and equals !pending_full. It drops the cycle after a transfer and rises the cycle after the commit.
  - frm_valid while frm_ready = 0 is ignored. The producer holds its data; no overwrite occurs.
- Commit:
  - At a frame boundary with pending full: display buffer ← pending, pending cleared, frm_commit = 1 for that one cycle.
  - Transfer and boundary on the same edge with pending empty: data goes to pending and commits at the next boundary, not this one.
  - Commit with pending full cannot coincide with a transfer, because frm_ready = 0.
- Output generation (registered, one-cycle latency from counter/index):
  - While counter < DEAD_CNT: sel = 0 and seg = 8'hFF.
  - Otherwise: sel = 1 << index.
    - If blank[index] = 1: seg = 8'hFF.
    - Else: seg = {~dp[index], hexdec(hex[index])[6:0]}.
- Hex decode, 7-bit active-low g..a:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, B=03, C=46, D=21, E=06, F=0E
- en = 0:
  - Counter and index forced to 0; sel = 0 and seg = 8'hFF on the next cycle.
  - The handshake still runs. Commits do not happen, because there are no ticks.
  - When en returns to 1, scanning restarts at digit 0 slot start, including dead time.
- Reset mid-operation discards both buffers immediately and asynchronously; outputs return to reset values.

Decomposition:
- Package seg_pkg:
  - SEG_DIGITS = 6
  - SEG_OFF = 8'hFF
  - 16-entry hex-to-segment constant table (values above)
  - Helper typedef for a frame struct {hex[23:0], dp[5:0], blank[5:0]}
- Sub-module seg_hex_decode: purely combinational nibble → 7-bit active-low pattern using the package table. It is shared with future display blocks.

Test Plan (SCAN_CNT = 8, DEAD_CNT = 2):
- Reset release, no frame, en = 1 → sel cycles 000001→…→100000, each active 6 of 8 cycles; seg = FF throughout (all blanked).
- Push frame hex = 24'hFEDCBA, dp = 0, blank = 0 at cycle 5 → frm_ready low next cycle; frm_commit at first index-5 tick; digit 0 then shows seg = 88 (A), digit 5 shows 8E (F).
- Push frame hex = 24'h012345, dp = 6'b000100 → digit 2 shows seg = 30 with bit7 = 0, i.e. 8'h30; frm_ready returns to 1 the cycle after commit.
- Second frm_valid while pending is full → not accepted; producer holds it, and it is accepted the cycle frm_ready rises; no data loss, commits in order.
- blank = 6'b101010 → digits 1, 3, 5 get sel asserted but seg = FF; digits 0, 2, 4 show decoded values.
- en low mid-slot on digit 3 → next cycle sel = 0, seg = FF; en high → first active digit is 0 after 2 dead cycles.
- Assert rst mid-frame with pending full → sel = 0, seg = FF and frm_ready = 1 immediately; display stays dark after release.
